// File: rtl/adder_arbiter_if.sv
// Request/response bus for the adder arbiter, including the link to the shared adder.
// The master side is the arbiter; the slave side is the requesters and the adder.
interface adder_arbiter_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 4,
  parameter int unsigned CW = 16
);
  localparam int unsigned IdW = $clog2(N);

  logic [N-1:0]   io_req_valid;
  logic [N-1:0]   io_req_ready;
  logic [N*W-1:0] io_req_a;
  logic [N*W-1:0] io_req_b;
  logic [N-1:0]   io_resp_valid;
  logic [N-1:0]   io_resp_ready;
  logic [W-1:0]   io_resp_sum;
  logic [IdW-1:0] io_resp_id;
  logic [W-1:0]   io_add_a;
  logic [W-1:0]   io_add_b;
  logic [W-1:0]   io_add_sum;
  logic           io_busy;
  logic [CW-1:0]  io_op_count;

  modport master (
    input  io_req_valid, io_req_a, io_req_b, io_resp_ready, io_add_sum,
    output io_req_ready, io_resp_valid, io_resp_sum, io_resp_id, io_add_a, io_add_b,
           io_busy, io_op_count
  );

  modport slave (
    output io_req_valid, io_req_a, io_req_b, io_resp_ready, io_add_sum,
    input  io_req_ready, io_resp_valid, io_resp_sum, io_resp_id, io_add_a, io_add_b,
           io_busy, io_op_count
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin scheduler sharing one combinational adder among N requesters.
// One operation in flight: accept in IDLE, drive the adder in ISSUE, hand back the sum in RESP.
module adder_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 4,
  parameter int unsigned CW = 16
) (
  input  logic            clock,
  input  logic            reset,
  adder_arbiter_if.master bus
);
  localparam int unsigned IdW  = $clog2(N);
  localparam int unsigned SumW = IdW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e         state_q, state_d;
  logic [IdW-1:0] ptr_q;
  logic [IdW-1:0] resp_id_q;
  logic [W-1:0]   add_a_q, add_b_q, resp_sum_q;
  logic [CW-1:0]  op_count_q;

  logic [W-1:0]   req_a_arr [N];
  logic [W-1:0]   req_b_arr [N];
  logic           grant_vld;
  logic [IdW-1:0] grant_id;
  logic [SumW-1:0] scan;
  logic           req_hs;
  logic           resp_hs;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign req_a_arr[i] = bus.io_req_a[i*W +: W];
    assign req_b_arr[i] = bus.io_req_b[i*W +: W];
  end

  // First valid requester scanning upward from ptr, wrapping modulo N.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    scan      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      scan = {1'b0, ptr_q} + SumW'(k);
      if (scan >= SumW'(N)) scan = scan - SumW'(N);
      if (!grant_vld && bus.io_req_valid[IdW'(scan)]) begin
        grant_vld = 1'b1;
        grant_id  = IdW'(scan);
      end
    end
  end

  assign req_hs  = (state_q == StIdle) && grant_vld;
  assign resp_hs = (state_q == StResp) && bus.io_resp_ready[resp_id_q];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant_vld) state_d = StIssue;
      StIssue: state_d = StResp;
      StResp:  if (resp_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.io_req_ready  = '0;
    bus.io_resp_valid = '0;
    for (int unsigned i = 0; i < N; i++) begin
      bus.io_req_ready[i]  = req_hs && (grant_id == IdW'(i));
      bus.io_resp_valid[i] = (state_q == StResp) && (resp_id_q == IdW'(i));
    end
    bus.io_busy = (state_q != StIdle);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      resp_id_q  <= '0;
      add_a_q    <= '0;
      add_b_q    <= '0;
      resp_sum_q <= '0;
      op_count_q <= '0;
    end else begin
      if (req_hs) begin
        add_a_q   <= req_a_arr[grant_id];
        add_b_q   <= req_b_arr[grant_id];
        resp_id_q <= grant_id;
      end
      if (state_q == StIssue) resp_sum_q <= bus.io_add_sum;
      if (resp_hs) begin
        // Pointer moves past the requester just served, so it has lowest priority next.
        ptr_q      <= (resp_id_q == IdW'(N - 1)) ? '0 : resp_id_q + 1'b1;
        op_count_q <= op_count_q + 1'b1;
      end
    end
  end

  assign bus.io_add_a      = add_a_q;
  assign bus.io_add_b      = add_b_q;
  assign bus.io_resp_sum   = resp_sum_q;
  assign bus.io_resp_id    = resp_id_q;
  assign bus.io_op_count   = op_count_q;
endmodule
